// File: rtl/alu_op_sequencer_if.sv
// Request/result port group between the control unit and alu_op_sequencer.
// master: control unit side; slave: sequencer side.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_y;
  logic [31:0] req_b;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_op, req_y, req_b,
    input  req_ready, res_hi, res_lo, done, err
  );

  modport slave (
    input  req_valid, req_op, req_y, req_b,
    output req_ready, res_hi, res_lo, done, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU operation at a time, holds the ALU
// operands stable, waits one cycle (or for divider completion on DIV),
// captures Zhigh/Zlo into HI/LO and pulses done.
// Optional feature macro: ALU_SEQ_DIV_WATCHDOG_EN (DIV_WAIT timeout after
// DIV_TIMEOUT cycles; abandon writes zero results and raises err).
module alu_op_sequencer #(
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave ctl,
  output logic [4:0]        alu_op_sel,
  output logic [31:0]       alu_y,
  output logic [31:0]       alu_b,
  output logic              alu_div_clr,
  input  logic [31:0]       alu_zhigh,
  input  logic [31:0]       alu_zlo,
  input  logic              alu_calc_finished
);

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b01111;

  if (DIV_TIMEOUT < 2 || DIV_TIMEOUT > 255) begin : g_timeout_range
    $error("alu_op_sequencer: DIV_TIMEOUT must be within 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_DIV_CLR,
    S_DIV_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_done;
  logic        r_div_clr;
  logic        r_first;
  logic [4:0]  r_op;
  logic [31:0] r_y;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

`ifdef ALU_SEQ_DIV_WATCHDOG_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(DIV_TIMEOUT);
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_inc;
  logic       r_err;
  assign w_cnt_inc = r_cnt + 8'd1;
`endif

  // Sequencer FSM: handshake, operand registers, result capture, done/err pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_div_clr <= 1'b0;
      r_first   <= 1'b0;
      r_op      <= OP_ADD;
      r_y       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef ALU_SEQ_DIV_WATCHDOG_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_div_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctl.req_valid) begin
            r_op    <= ctl.req_op;
            r_y     <= ctl.req_y;
            r_b     <= ctl.req_b;
            r_ready <= 1'b0;
`ifdef ALU_SEQ_DIV_WATCHDOG_EN
            r_err   <= 1'b0;
`endif
            if (ctl.req_op == OP_DIV) begin
              r_div_clr <= 1'b1;
              r_state   <= S_DIV_CLR;
            end else begin
              r_state   <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_hi    <= alu_zhigh;
          r_lo    <= alu_zlo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DIV_CLR: begin
          r_first <= 1'b1;
`ifdef ALU_SEQ_DIV_WATCHDOG_EN
          r_cnt   <= '0;
`endif
          r_state <= S_DIV_WAIT;
        end
        S_DIV_WAIT: begin
          r_first <= 1'b0;
          // Completion is tested before expiry so a same-cycle finish still captures.
          if (!r_first && alu_calc_finished) begin
            r_hi    <= alu_zhigh;
            r_lo    <= alu_zlo;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
`ifdef ALU_SEQ_DIV_WATCHDOG_EN
          else if (w_cnt_inc == LP_TIMEOUT) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
`endif
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ctl.req_ready = r_ready;
  assign ctl.res_hi    = r_hi;
  assign ctl.res_lo    = r_lo;
  assign ctl.done      = r_done;
`ifdef ALU_SEQ_DIV_WATCHDOG_EN
  assign ctl.err       = r_err;
`else
  assign ctl.err       = 1'b0;
`endif
  assign alu_op_sel    = r_op;
  assign alu_y         = r_y;
  assign alu_b         = r_b;
  assign alu_div_clr   = r_div_clr;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU stub, directed scenarios and
// randomized operations checked against a cycle-latency/result reference model.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_DIV_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int TO = 8;

  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_MUL   = 5'b01110;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_UNDEF = 5'b11010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  alu_op_sel;
  logic [31:0] alu_y;
  logic [31:0] alu_b;
  logic        alu_div_clr;
  logic [31:0] alu_zhigh;
  logic [31:0] alu_zlo;
  logic        alu_calc_finished = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;

  alu_op_sequencer_if ctl ();

  alu_op_sequencer #(.DIV_TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .ctl               (ctl),
    .alu_op_sel        (alu_op_sel),
    .alu_y             (alu_y),
    .alu_b             (alu_b),
    .alu_div_clr       (alu_div_clr),
    .alu_zhigh         (alu_zhigh),
    .alu_zlo           (alu_zlo),
    .alu_calc_finished (alu_calc_finished)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural ALU: {Zhigh, Zlo} for an op; unknown codes behave as ADD.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
    case (op)
      OP_SUB:  return {32'd0, y - b};
      OP_AND:  return {32'd0, y & b};
      OP_OR:   return {32'd0, y | b};
      OP_XOR:  return {32'd0, y ^ b};
      OP_MUL:  return 64'(y) * 64'(b);
      OP_DIV:  return (b == 32'd0) ? {y, 32'hFFFF_FFFF} : {y % b, y / b};
      default: return {32'd0, y + b};
    endcase
  endfunction

  assign {alu_zhigh, alu_zlo} = alu_fn(alu_op_sel, alu_y, alu_b);

  // Reference: latency from acceptance edge to done-visible, results and err.
  // fin_k = first cycle index after acceptance (0 = clear cycle) with the
  // finish flag high; the first wait cycle (index 1) never counts.
  task automatic ref_op(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b,
                        input int fin_k, output int lat, output logic [31:0] hi,
                        output logic [31:0] lo, output logic err);
    int kc;
    logic [63:0] r;
    r = alu_fn(op, y, b);
    if (op != OP_DIV) begin
      lat = 2; hi = r[63:32]; lo = r[31:0]; err = 1'b0;
    end else begin
      kc = (fin_k < 2) ? 2 : fin_k;
      if (WD && kc > TO) begin
        lat = TO + 2; hi = '0; lo = '0; err = 1'b1;
      end else begin
        lat = kc + 2; hi = r[63:32]; lo = r[31:0]; err = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to done (bounded). lat=-1 if done never seen.
  task automatic drive_op(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b,
                          input int fin_k, input bit stale, input bit keep_valid,
                          output int lat, output int acc_cyc, output int clr_pulses,
                          output int rdy_hi);
    int guard;
    lat = -1; clr_pulses = 0; rdy_hi = 0;
    ctl.req_op = op; ctl.req_y = y; ctl.req_b = b; ctl.req_valid = 1'b1;
    guard = 0;
    while (ctl.req_ready !== 1'b1 && guard < 50) begin
      cyc();
      guard++;
    end
    alu_calc_finished = stale;
    cyc();
    acc_cyc = cyc_cnt;
    if (!keep_valid) ctl.req_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      alu_calc_finished = (k >= fin_k) || (stale && k <= 1);
      if (alu_div_clr === 1'b1) clr_pulses++;
      if (ctl.req_ready !== 1'b0) rdy_hi++;
      cyc();
      if (ctl.done === 1'b1) begin
        lat = k + 2;
        break;
      end
    end
    alu_calc_finished = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    ctl.req_valid = 1'b0; ctl.req_op = '0; ctl.req_y = '0; ctl.req_b = '0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (ctl.req_ready !== 1'b1) $display("FAIL rst_ready: got %0b expected 1", ctl.req_ready); else n_pass++;
    n_checks++; if (ctl.done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", ctl.done); else n_pass++;
    n_checks++; if (ctl.err !== 1'b0) $display("FAIL rst_err: got %0b expected 0", ctl.err); else n_pass++;
    n_checks++; if (alu_div_clr !== 1'b0) $display("FAIL rst_clr: got %0b expected 0", alu_div_clr); else n_pass++;
    n_checks++; if (alu_op_sel !== OP_ADD) $display("FAIL rst_opsel: got %b expected %b", alu_op_sel, OP_ADD); else n_pass++;
    n_checks++; if ({alu_y, alu_b} !== 64'd0) $display("FAIL rst_operands: got %h expected 0", {alu_y, alu_b}); else n_pass++;
    n_checks++; if ({ctl.res_hi, ctl.res_lo} !== 64'd0) $display("FAIL rst_res: got %h expected 0", {ctl.res_hi, ctl.res_lo}); else n_pass++;
    cyc();
    reset = 1'b1;
    cyc();
    n_checks++; if (ctl.req_ready !== 1'b1) $display("FAIL rst_idle_ready: got %0b expected 1", ctl.req_ready); else n_pass++;
  endtask

  task automatic test_add();
    int lat, acc, clr, rdy;
    drive_op(OP_ADD, 32'd5, 32'd7, 1000, 1'b0, 1'b0, lat, acc, clr, rdy);
    n_checks++; if (lat != 2) $display("FAIL add_latency: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (ctl.res_lo !== 32'd12) $display("FAIL add_lo: got %0d expected 12", ctl.res_lo); else n_pass++;
    n_checks++; if (ctl.res_hi !== 32'd0) $display("FAIL add_hi: got %0d expected 0", ctl.res_hi); else n_pass++;
    n_checks++; if (ctl.err !== 1'b0) $display("FAIL add_err: got %0b expected 0", ctl.err); else n_pass++;
    n_checks++; if (clr != 0) $display("FAIL add_clr: got %0d pulses expected 0", clr); else n_pass++;
    cyc();
    n_checks++; if (ctl.done !== 1'b0) $display("FAIL add_done_width: got %0b expected 0", ctl.done); else n_pass++;
    n_checks++; if (ctl.req_ready !== 1'b1) $display("FAIL add_ready_after: got %0b expected 1", ctl.req_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1, acc1, clr1, rdy1, lat2, acc2, clr2, rdy2;
    drive_op(OP_SUB, 32'd10, 32'd3, 1000, 1'b0, 1'b1, lat1, acc1, clr1, rdy1);
    n_checks++; if (ctl.res_lo !== 32'd7) $display("FAIL b2b_sub_lo: got %0d expected 7", ctl.res_lo); else n_pass++;
    n_checks++; if (rdy1 != 0) $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", rdy1); else n_pass++;
    drive_op(OP_AND, 32'd6, 32'd3, 1000, 1'b0, 1'b0, lat2, acc2, clr2, rdy2);
    n_checks++; if (acc2 - acc1 != 3) $display("FAIL b2b_spacing: got %0d cycles expected 3", acc2 - acc1); else n_pass++;
    n_checks++; if (ctl.res_lo !== 32'd2) $display("FAIL b2b_and_lo: got %0d expected 2", ctl.res_lo); else n_pass++;
    n_checks++; if (lat2 != 2) $display("FAIL b2b_latency: got %0d expected 2", lat2); else n_pass++;
  endtask

  task automatic test_div();
    int lat, acc, clr, rdy, elat, fk;
    logic [31:0] ehi, elo;
    logic eerr;
    fk = WD ? 6 : 10;
    ref_op(OP_DIV, 32'd17, 32'd5, fk, elat, ehi, elo, eerr);
    drive_op(OP_DIV, 32'd17, 32'd5, fk, 1'b1, 1'b0, lat, acc, clr, rdy);
    n_checks++; if (clr != 1) $display("FAIL div_clr_pulse: got %0d cycles expected 1", clr); else n_pass++;
    n_checks++; if (lat != elat) $display("FAIL div_latency: got %0d expected %0d", lat, elat); else n_pass++;
    n_checks++; if (ctl.res_hi !== 32'd2) $display("FAIL div_rem: got %0d expected 2", ctl.res_hi); else n_pass++;
    n_checks++; if (ctl.res_lo !== 32'd3) $display("FAIL div_quot: got %0d expected 3", ctl.res_lo); else n_pass++;
    n_checks++; if (ctl.err !== eerr) $display("FAIL div_err: got %0b expected %0b", ctl.err, eerr); else n_pass++;
  endtask

  task automatic test_watchdog();
    int lat, acc, clr, rdy;
    drive_op(OP_DIV, 32'd100, 32'd7, 100000, 1'b0, 1'b0, lat, acc, clr, rdy);
    if (WD) begin
      n_checks++; if (lat != TO + 2) $display("FAIL wd_latency: got %0d expected %0d", lat, TO + 2); else n_pass++;
      n_checks++; if (ctl.err !== 1'b1) $display("FAIL wd_err: got %0b expected 1", ctl.err); else n_pass++;
      n_checks++; if ({ctl.res_hi, ctl.res_lo} !== 64'd0) $display("FAIL wd_res: got %h expected 0", {ctl.res_hi, ctl.res_lo}); else n_pass++;
      cyc();
      n_checks++; if (ctl.err !== 1'b1) $display("FAIL wd_err_hold: got %0b expected 1", ctl.err); else n_pass++;
    end else begin
      n_checks++; if (lat != -1) $display("FAIL nowd_done: got latency %0d expected none", lat); else n_pass++;
      n_checks++; if (rdy != 0) $display("FAIL nowd_ready: got %0d ready cycles expected 0", rdy); else n_pass++;
      n_checks++; if (ctl.err !== 1'b0) $display("FAIL nowd_err: got %0b expected 0", ctl.err); else n_pass++;
      do_reset();
    end
  endtask

  task automatic test_collision();
    int lat, acc, clr, rdy, elat;
    logic [31:0] ehi, elo;
    logic eerr;
    ref_op(OP_DIV, 32'd1000, 32'd7, TO, elat, ehi, elo, eerr);
    drive_op(OP_DIV, 32'd1000, 32'd7, TO, 1'b0, 1'b0, lat, acc, clr, rdy);
    n_checks++; if (ctl.err !== 1'b0) $display("FAIL coll_err: got %0b expected 0", ctl.err); else n_pass++;
    n_checks++; if (lat != elat) $display("FAIL coll_latency: got %0d expected %0d", lat, elat); else n_pass++;
    n_checks++; if ({ctl.res_hi, ctl.res_lo} !== {ehi, elo}) $display("FAIL coll_res: got %h expected %h", {ctl.res_hi, ctl.res_lo}, {ehi, elo}); else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] ops [8];
    logic [4:0] op;
    logic [31:0] y, b, ehi, elo;
    logic eerr;
    int lat, acc, clr, rdy, elat, fk;
    bit stale;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_UNDEF};
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 7)];
      y = $urandom;
      b = (op == OP_DIV) ? 32'($urandom_range(1, 5000)) : $urandom;
      fk = $urandom_range(1, 12);
      stale = 1'($urandom_range(0, 1));
      ref_op(op, y, b, fk, elat, ehi, elo, eerr);
      drive_op(op, y, b, fk, stale, 1'b0, lat, acc, clr, rdy);
      n_checks++; if (lat != elat) $display("FAIL rnd%0d_latency: op %b got %0d expected %0d", i, op, lat, elat); else n_pass++;
      n_checks++; if ({ctl.res_hi, ctl.res_lo} !== {ehi, elo}) $display("FAIL rnd%0d_res: op %b got %h expected %h", i, op, {ctl.res_hi, ctl.res_lo}, {ehi, elo}); else n_pass++;
      n_checks++; if (ctl.err !== eerr) $display("FAIL rnd%0d_err: got %0b expected %0b", i, ctl.err, eerr); else n_pass++;
      n_checks++; if (clr != ((op == OP_DIV) ? 1 : 0)) $display("FAIL rnd%0d_clr: got %0d pulses expected %0d", i, clr, (op == OP_DIV) ? 1 : 0); else n_pass++;
      n_checks++; if (rdy != 0) $display("FAIL rnd%0d_ready: got %0d ready cycles expected 0", i, rdy); else n_pass++;
      n_checks++; if ({alu_op_sel, alu_y, alu_b} !== {op, y, b}) $display("FAIL rnd%0d_hold: got %h expected %h", i, {alu_op_sel, alu_y, alu_b}, {op, y, b}); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int lat, acc, clr, rdy;
    drive_op(OP_ADD, 32'd40, 32'd2, 1000, 1'b0, 1'b0, lat, acc, clr, rdy);
    n_checks++; if (ctl.res_lo !== 32'd42) $display("FAIL rmid_pre_lo: got %0d expected 42", ctl.res_lo); else n_pass++;
    cyc();
    ctl.req_op = OP_DIV; ctl.req_y = 32'd9; ctl.req_b = 32'd2; ctl.req_valid = 1'b1;
    alu_calc_finished = 1'b0;
    cyc();
    ctl.req_valid = 1'b0;
    cyc();
    cyc();
    n_checks++; if (ctl.req_ready !== 1'b0) $display("FAIL rmid_busy: got %0b expected 0", ctl.req_ready); else n_pass++;
    #3 reset = 1'b0;
    #1;
    n_checks++; if (ctl.req_ready !== 1'b1) $display("FAIL rmid_ready: got %0b expected 1", ctl.req_ready); else n_pass++;
    n_checks++; if ({ctl.res_hi, ctl.res_lo} !== 64'd0) $display("FAIL rmid_res: got %h expected 0", {ctl.res_hi, ctl.res_lo}); else n_pass++;
    n_checks++; if (alu_op_sel !== OP_ADD) $display("FAIL rmid_opsel: got %b expected %b", alu_op_sel, OP_ADD); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (ctl.done !== 1'b0) $display("FAIL rmid_done%0d: got %0b expected 0", i, ctl.done); else n_pass++;
    end
    reset = 1'b1;
    cyc();
    n_checks++; if (ctl.done !== 1'b0) $display("FAIL rmid_done_release: got %0b expected 0", ctl.done); else n_pass++;
    n_checks++; if (ctl.req_ready !== 1'b1) $display("FAIL rmid_ready_release: got %0b expected 1", ctl.req_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_div();
    test_watchdog();
    test_collision();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencing controller that sits in front of the ALU datapath and accepts one operation at a time from the control unit over a valid/ready handshake. It registers the operands and op select, drives the ALU, and waits one cycle for single-cycle ops or until the divider reports completion for DIV. It then captures Zhigh/Zlo into the HI/LO result registers and pulses done. It is the only owner of the ALU op_sel, operand and divider-clear inputs.

## Interface
- DIV_TIMEOUT, 64: cycles to wait for calc_finished before abandoning a DIV (range 2..255; used only with the watchdog).
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_op  input  5  ALU op code (same encoding as the ALU op_sel).
- req_y  input  32  first operand (Y / dividend).
- req_b  input  32  second operand (B / divisor / shift amount).
- req_ready  output  1  sequencer can accept a request.
- alu_op_sel  output  5  to ALU op_sel.
- alu_y, alu_b  output  32 each  to ALU Y and B.
- alu_div_clr  output  1  one-cycle active-high clear to the divider.
- alu_zhigh, alu_zlo  input  32 each  ALU results.
- alu_calc_finished  input  1  divider completion flag.
- res_hi, res_lo  output  32 each  captured result registers.
- done  output  1  one-cycle pulse: result registers just updated.
- err  output  1  with done: DIV abandoned by the watchdog.

## Operation
- States: IDLE, EXEC, DIV_CLR, DIV_WAIT, DONE.
- IDLE: req_ready=1. A handshake (req_valid & req_ready at an edge) registers req_op, req_y and req_b into the alu_* outputs.
  - DIV (5'b01111) goes to DIV_CLR; all other codes go to EXEC.
- EXEC: ALU output settles combinationally; res_hi <= alu_zhigh and res_lo <= alu_zlo at the end of the cycle; go to DONE.
- DIV_CLR: alu_div_clr=1 for exactly this cycle; zero the watchdog counter; go to DIV_WAIT.
- DIV_WAIT: alu_calc_finished is ignored in the first cycle, which masks a stale flag from the previous division. From the second cycle, alu_calc_finished=1 captures res_hi/res_lo (remainder in HI, quotient in LO) and goes to DONE.
- DONE: done=1 and req_ready=0 for one cycle; return to IDLE.
- Undefined op codes are issued as-is; the ALU default (ADD) result is captured. No error is flagged.
- alu_* operand/op outputs hold their values from acceptance until the next acceptance, so the ALU inputs stay stable through capture.
- err is cleared at every acceptance and set only by a watchdog abandon.

## Timing
- Reset (reset=0, async):
  - state=IDLE.
  - req_ready=1, done=0, err=0, alu_div_clr=0.
  - alu_op_sel=5'b00011 (ADD); alu_y, alu_b, res_hi and res_lo all 0.
- Non-DIV latency: accept at edge T0, capture at T1, done high during the cycle after T1. Throughput is one op per 3 cycles.
- DIV latency: accept at T0, clear cycle, then at least 2 DIV_WAIT cycles; done follows the capture edge.
- req_ready is low in every state except IDLE. req_valid is ignored when req_ready=0, and requests are never queued.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced, and res_hi/res_lo return to 0.
- If alu_calc_finished and watchdog expiry happen in the same cycle, completion wins: err=0 and the result is captured.

## Configuration
- ALU_SEQ_DIV_WATCHDOG_EN defined:
  - An 8-bit counter increments in each DIV_WAIT cycle.
  - When the count reaches DIV_TIMEOUT without completion, res_hi and res_lo are written to 0, err=1, and the state goes to DONE.
- Undefined: no counter; DIV_WAIT waits indefinitely for alu_calc_finished, and err is tied to 0.

## Test plan
- Reset: reset low mid-DIV_WAIT -> immediately req_ready=1, res_hi=res_lo=0, alu_op_sel=5'b00011, no done pulse.
- ADD: op 5'b00011, Y=5, B=7 -> done exactly 2 cycles after acceptance; res_lo=12, res_hi=0, err=0.
- Back-to-back: req_valid held high with SUB (Y=10, B=3), then AND (Y=6, B=3) -> results res_lo=7 then res_lo=2; req_ready=0 between accepts; the second accept occurs 3 cycles after the first.
- DIV: Y=17, B=5; alu_calc_finished already high on entry and re-asserted 10 cycles later -> alu_div_clr is a single-cycle pulse; the stale flag is ignored; capture gives res_hi=2 (remainder), res_lo=3 (quotient).
- Watchdog (macro on, DIV_TIMEOUT=8): DIV with alu_calc_finished held low -> done with err=1 and res_hi=res_lo=0 after 8 DIV_WAIT cycles. With the macro off, the same stimulus leaves req_ready low for more than 100 cycles.
- Collision: alu_calc_finished rises in the expiry cycle -> err=0 and the ALU result is captured.
